mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH, default 256: data-memory depth in 32-bit words, power of two.
REQ-002 Port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port i_reset  input  1  synchronous, active-low reset.
REQ-004 Port i_ex_m_alu_result  input  32  byte address for loads and stores, and pass-through ALU result.
REQ-005 Port i_ex_m_write_data  input  32  store data, right-aligned.
REQ-006 Port i_ex_m_rd  input  5  destination register ID.
REQ-007 Ports i_ex_m_mem_read, i_ex_m_mem_write, i_ex_m_mem_to_reg, i_ex_m_reg_write  input  1 each  control bits from the EX/M stage.
REQ-008 Port i_ex_m_size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-009 Port i_ex_m_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 Ports o_m_wb_read_data, o_m_wb_alu_result  output  32 each  registered load data and registered ALU result.
REQ-011 Ports o_m_wb_rd  output  5; o_m_wb_mem_to_reg, o_m_wb_reg_write  output  1 each  registered pass-through fields.
REQ-012 Port i_dbg_addr  input  log2(DEPTH)  debug word index.
REQ-013 Port o_dbg_data  output  32  combinational memory word at i_dbg_addr.
REQ-014 Port o_m_misaligned  output  1  registered misaligned-access flag; present only when MEM_ALIGN_CHECK_EN is defined.

Function
REQ-015 Word index SHALL be i_ex_m_alu_result[log2(DEPTH)+1:2]; the upper address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-016 Byte lane SHALL be address[1:0]; halfword lane SHALL be address[1].
REQ-017 Store, when i_ex_m_mem_write=1, SHALL write only the addressed lanes at the clock edge: byte uses write_data[7:0], halfword uses write_data[15:0], word uses all 32 bits; the other bytes SHALL be unchanged.
REQ-018 Load, when i_ex_m_mem_read=1, SHALL extract the addressed byte or halfword, extend it per i_ex_m_unsigned, and register it into o_m_wb_read_data at the same edge (one-cycle latency).
REQ-019 When i_ex_m_mem_read=0, o_m_wb_read_data SHALL load 0.
REQ-020 Load read data SHALL be taken from memory contents before any same-edge store.
REQ-021 A load issued in the cycle after a store to the same word SHALL return the newly stored data.
REQ-022 If i_ex_m_mem_read and i_ex_m_mem_write are both 1, the store SHALL take effect and o_m_wb_read_data SHALL carry the old word, extended per REQ-018.
REQ-023 On every non-reset edge, o_m_wb_alu_result, o_m_wb_rd, o_m_wb_mem_to_reg and o_m_wb_reg_write SHALL take their EX/M inputs unchanged.
REQ-024 o_dbg_data SHALL reflect any store one cycle after the write edge.

Reset
REQ-025 When i_reset=0 at a rising edge, all o_m_wb_* outputs and o_m_misaligned SHALL become 0.
REQ-026 A store presented in a reset cycle SHALL be suppressed.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 All outputs SHALL be 0 on the first edge after reset deasserts only if the inputs are 0.

Configuration
REQ-029 With MEM_ALIGN_CHECK_EN defined, a halfword access with address[0]=1 or a word access with address[1:0]!=0 SHALL suppress the store, force o_m_wb_read_data to 0 and o_m_wb_reg_write to 0, and set o_m_misaligned=1 for that one cycle.
REQ-030 Without MEM_ALIGN_CHECK_EN, o_m_misaligned SHALL be absent; low address bits are ignored for word accesses and only address[1] is used for halfword accesses.

Verification
REQ-031 SW 0xDEADBEEF to address 0x10, then LW 0x10: o_m_wb_read_data=0xDEADBEEF one cycle after the load.
REQ-032 SB 0x7F to 0x13 over 0x00000000, then LB 0x13 gives 0x0000007F; SB 0x80 to 0x13, then LB gives 0xFFFFFF80 and LBU gives 0x00000080.
REQ-033 Word 0x12348765 at 0x20: LH 0x20 gives 0xFFFF8765; LHU 0x22 gives 0x00001234.
REQ-034 Address 0x400 with DEPTH=256 aliases to 0x000: SW to 0x400, then i_dbg_addr=0 shows the stored data.
REQ-035 Assert reset mid-stream while SW 0x1 to 0x8 is presented: all outputs become 0 and word 2 keeps its old value.
REQ-036 With MEM_ALIGN_CHECK_EN defined, SW to 0x6: memory unchanged, o_m_misaligned=1 for one cycle, o_m_wb_reg_write=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: byte-lane data memory with sized loads/stores and registered M/WB outputs.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int DEPTH = 256
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [31:0]              i_ex_m_alu_result,
    input  logic [31:0]              i_ex_m_write_data,
    input  logic [4:0]               i_ex_m_rd,
    input  logic                     i_ex_m_mem_read,
    input  logic                     i_ex_m_mem_write,
    input  logic                     i_ex_m_mem_to_reg,
    input  logic                     i_ex_m_reg_write,
    input  logic [1:0]               i_ex_m_size,
    input  logic                     i_ex_m_unsigned,
    output logic [31:0]              o_m_wb_read_data,
    output logic [31:0]              o_m_wb_alu_result,
    output logic [4:0]               o_m_wb_rd,
    output logic                     o_m_wb_mem_to_reg,
    output logic                     o_m_wb_reg_write,
    input  logic [$clog2(DEPTH)-1:0] i_dbg_addr,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                     o_m_misaligned,
`endif
    output logic [31:0]              o_dbg_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          misaligned;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;
    logic          store_en;
    logic [31:0]   old_word;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_ext;
    logic [31:0]   read_data_next;

    assign word_idx = i_ex_m_alu_result[AW+1:2];
    assign lane     = i_ex_m_alu_result[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((i_ex_m_size == 2'b01) && lane[0]) ||
                        (i_ex_m_size[1] && (lane != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Store data is replicated across lanes so each lane only needs its own slice.
    always_comb begin
        byte_en = 4'b1111;
        wr_data = i_ex_m_write_data;
        case (i_ex_m_size)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{i_ex_m_write_data[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{i_ex_m_write_data[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_data = i_ex_m_write_data;
            end
        endcase
    end

    assign store_en = i_reset && i_ex_m_mem_write && !misaligned;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];

            always_ff @(posedge i_clk) begin
                if (store_en && byte_en[gi]) begin
                    mem_lane[word_idx] <= wr_data[gi*8 +: 8];
                end
            end

            assign old_word[gi*8 +: 8]   = mem_lane[word_idx];
            assign o_dbg_data[gi*8 +: 8] = mem_lane[i_dbg_addr];
        end
    endgenerate

    assign load_byte = old_word[{lane, 3'b000} +: 8];
    assign load_half = lane[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        load_ext = old_word;
        case (i_ex_m_size)
            2'b00:   load_ext = i_ex_m_unsigned ? {24'd0, load_byte}
                                                : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_ext = i_ex_m_unsigned ? {16'd0, load_half}
                                                : {{16{load_half[15]}}, load_half};
            default: load_ext = old_word;
        endcase
    end

    assign read_data_next = (i_ex_m_mem_read && !misaligned) ? load_ext : 32'd0;

    logic [31:0] read_data_reg;
    logic [31:0] alu_result_reg;
    logic [4:0]  rd_reg;
    logic        mem_to_reg_reg;
    logic        reg_write_reg;
    logic        misaligned_reg;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            read_data_reg  <= 32'd0;
            alu_result_reg <= 32'd0;
            rd_reg         <= 5'd0;
            mem_to_reg_reg <= 1'b0;
            reg_write_reg  <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            read_data_reg  <= read_data_next;
            alu_result_reg <= i_ex_m_alu_result;
            rd_reg         <= i_ex_m_rd;
            mem_to_reg_reg <= i_ex_m_mem_to_reg;
            reg_write_reg  <= i_ex_m_reg_write && !misaligned;
            misaligned_reg <= misaligned;
        end
    end

    assign o_m_wb_read_data  = read_data_reg;
    assign o_m_wb_alu_result = alu_result_reg;
    assign o_m_wb_rd         = rd_reg;
    assign o_m_wb_mem_to_reg = mem_to_reg_reg;
    assign o_m_wb_reg_write  = reg_write_reg;

`ifdef MEM_ALIGN_CHECK_EN
    assign o_m_misaligned = misaligned_reg;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned_reg;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a reference memory model predicts every M/WB output.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  rd = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic        reg_write = 1'b0;
    logic [1:0]  size = '0;
    logic        uns = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] wb_read_data, wb_alu_result, dbg_data;
    logic [4:0]  wb_rd;
    logic        wb_mem_to_reg, wb_reg_write;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned_out;
`endif

    mem_stage #(.DEPTH(256)) dut (
        .i_clk             (clk),
        .i_reset           (rst_n),
        .i_ex_m_alu_result (alu_result),
        .i_ex_m_write_data (write_data),
        .i_ex_m_rd         (rd),
        .i_ex_m_mem_read   (mem_read),
        .i_ex_m_mem_write  (mem_write),
        .i_ex_m_mem_to_reg (mem_to_reg),
        .i_ex_m_reg_write  (reg_write),
        .i_ex_m_size       (size),
        .i_ex_m_unsigned   (uns),
        .o_m_wb_read_data  (wb_read_data),
        .o_m_wb_alu_result (wb_alu_result),
        .o_m_wb_rd         (wb_rd),
        .o_m_wb_mem_to_reg (wb_mem_to_reg),
        .o_m_wb_reg_write  (wb_reg_write),
        .i_dbg_addr        (dbg_addr),
`ifdef MEM_ALIGN_CHECK_EN
        .o_m_misaligned    (misaligned_out),
`endif
        .o_dbg_data        (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [256];
    int          errors = 0;
    int          checks = 0;
    bit          have_store = 1'b0;
    logic [7:0]  last_idx = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        $display("txn %s: rdata=%h alu=%h rd=%0d rw=%0b", e.name, wb_read_data,
                 wb_alu_result, wb_rd, wb_reg_write);
        check({e.name, ".rdata"}, wb_read_data, e.rdata);
        check({e.name, ".alu"}, wb_alu_result, e.alu);
        check({e.name, ".rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
        check({e.name, ".m2r"}, {31'd0, wb_mem_to_reg}, {31'd0, e.m2r});
        check({e.name, ".rw"}, {31'd0, wb_reg_write}, {31'd0, e.rw});
`ifdef MEM_ALIGN_CHECK_EN
        check({e.name, ".mis"}, {31'd0, misaligned_out}, {31'd0, e.mis});
`endif
    endtask

    task automatic op(input string name, input bit r_n, input bit rd_en, input bit wr_en,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] sz, input bit u);
        exp_t        e;
        logic [7:0]  idx;
        logic [1:0]  ln;
        logic [31:0] old;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ext;
        bit          mis;
        bit          be;
        logic [7:0]  d;

        @(negedge clk);
        if (have_store) begin
            dbg_addr = last_idx;
            #1;
            check("dbg", dbg_data, model_mem[last_idx]);
        end
        compare_out();

        rst_n      = r_n;
        mem_read   = rd_en;
        mem_write  = wr_en;
        alu_result = addr;
        write_data = wdata;
        size       = sz;
        uns        = u;
        rd         = 5'($urandom);
        mem_to_reg = 1'($urandom);
        reg_write  = 1'($urandom);

        idx = addr[9:2];
        ln  = addr[1:0];
        old = model_mem[idx];
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((sz == 2'b01) && ln[0]) || ((sz == 2'b10 || sz == 2'b11) && ln != 2'b00);
`else
        mis = 1'b0;
`endif
        b = 8'(old >> (8 * ln));
        h = ln[1] ? old[31:16] : old[15:0];
        if (sz == 2'b00)      ext = u ? {24'd0, b} : {{24{b[7]}}, b};
        else if (sz == 2'b01) ext = u ? {16'd0, h} : {{16{h[15]}}, h};
        else                  ext = old;

        e.name  = name;
        e.rdata = (r_n && rd_en && !mis) ? ext : 32'd0;
        e.alu   = r_n ? addr : 32'd0;
        e.rd    = r_n ? rd : 5'd0;
        e.m2r   = r_n ? mem_to_reg : 1'b0;
        e.rw    = r_n ? (reg_write && !mis) : 1'b0;
        e.mis   = r_n ? mis : 1'b0;
        sb_q.push_back(e);

        if (r_n && wr_en && !mis) begin
            for (int k = 0; k < 4; k++) begin
                if (sz == 2'b00)      be = (k == int'(ln));
                else if (sz == 2'b01) be = ((k / 2) == int'(ln[1]));
                else                  be = 1'b1;
                if (sz == 2'b00)      d = wdata[7:0];
                else if (sz == 2'b01) d = wdata[(k % 2) * 8 +: 8];
                else                  d = wdata[k * 8 +: 8];
                if (be) model_mem[idx][k * 8 +: 8] = d;
            end
            have_store = 1'b1;
            last_idx   = idx;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;

        op("reset0", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        op("reset1", 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0);

        for (int i = 0; i < 256; i++)
            op("init", 1'b1, 1'b0, 1'b1, 32'(i * 4), 32'h0, 2'b10, 1'b0);

        op("sw_beef", 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        op("lw_beef", 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        op("sb_7f",   1'b1, 1'b0, 1'b1, 32'h13, 32'h7F, 2'b00, 1'b0);
        op("lb_7f",   1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0);
        op("sb_80",   1'b1, 1'b0, 1'b1, 32'h13, 32'hFFFFFF80, 2'b00, 1'b0);
        op("lb_80",   1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0);
        op("lbu_80",  1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1);
        op("sw_8765", 1'b1, 1'b0, 1'b1, 32'h20, 32'h12348765, 2'b10, 1'b0);
        op("lh_20",   1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b01, 1'b0);
        op("lhu_22",  1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b1);
        op("sh_22",   1'b1, 1'b0, 1'b1, 32'h22, 32'hAAAA5A5A, 2'b01, 1'b0);
        op("lw_20",   1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0);
        op("sw_alias",1'b1, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 2'b10, 1'b0);
        op("lw_0",    1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        op("sw_rst",  1'b0, 1'b0, 1'b1, 32'h8, 32'h1, 2'b10, 1'b0);
        op("lw_8",    1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0);
        op("rw_same", 1'b1, 1'b1, 1'b1, 32'h10, 32'h01234567, 2'b10, 1'b0);
        op("lw_new",  1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        op("sw_6",    1'b1, 1'b0, 1'b1, 32'h6, 32'h55667788, 2'b10, 1'b0);
        op("lw_4",    1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0);
        op("lh_odd",  1'b1, 1'b1, 1'b0, 32'h21, 32'h0, 2'b01, 1'b0);

        for (int i = 0; i < 300; i++)
            op("rand", 1'b1, 1'($urandom), 1'($urandom), 32'($urandom_range(0, 32'h7FF)),
               $urandom, 2'($urandom), 1'($urandom));

        @(negedge clk);
        compare_out();
        if (sb_q.size() != 0) check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
